// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_tx_edge_det.sv
// Rising-edge detector with async active-low reset; reused by the detector board.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev_r;

    // History of din; cleared in reset so a level held across release reads as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= din;
        end
    end

    assign rise = din & ~prev_r;

endmodule

// File: rtl/seq_tx.sv
// seq_tx: sends a latched pattern MSB first, DIV clocks per bit, on a start edge.
// Optional macro SEQ_TX_LOOP_EN: repeat the latched pattern until the next start edge.
module seq_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [15:0]      DIV_LAST = 16'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAT_W);

    state_e           state_r, state_s;
    logic [PAT_W-1:0] shift_r, shift_s, shifted_s;
    logic [15:0]      div_r, div_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             ser_r, ser_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             start_rise_s;
    logic             load_s;
    logic             bit_end_s;
    logic             last_bit_s;
`ifdef SEQ_TX_LOOP_EN
    logic [PAT_W-1:0] pat_r;
`endif

    edge_det u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (start),
        .rise  (start_rise_s)
    );

    assign shifted_s = {shift_r[PAT_W-2:0], 1'b0};

    // Next-state and next-output computation; a start edge that loads overrides the FSM.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        div_s      = div_r;
        cnt_s      = cnt_r;
        ser_s      = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        bit_end_s  = (div_r == DIV_LAST);
        last_bit_s = bit_end_s && (cnt_r == CNT_LAST);
`ifdef SEQ_TX_LOOP_EN
        load_s     = start_rise_s && (state_r != SEND);
`else
        load_s     = start_rise_s;
`endif
        if (load_s) begin
            state_s = SEND;
            shift_s = pattern;
            div_s   = 16'd0;
            cnt_s   = {CNT_W{1'b0}};
            ser_s   = pattern[PAT_W-1];
            busy_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                SEND: begin
                    busy_s = 1'b1;
`ifdef SEQ_TX_LOOP_EN
                    // While looping, a start edge is the stop request.
                    if (start_rise_s) begin
                        state_s = IDLE;
                        busy_s  = 1'b0;
                        div_s   = 16'd0;
                    end else if (last_bit_s) begin
                        shift_s = pat_r;
                        div_s   = 16'd0;
                        cnt_s   = {CNT_W{1'b0}};
                        ser_s   = pat_r[PAT_W-1];
                        done_s  = 1'b1;
                    end else
`else
                    if (last_bit_s) begin
                        state_s = FIN;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        div_s   = 16'd0;
                        cnt_s   = CNT_FULL;
                        shift_s = {PAT_W{1'b0}};
                    end else
`endif
                    if (bit_end_s) begin
                        shift_s = shifted_s;
                        div_s   = 16'd0;
                        cnt_s   = cnt_r + CNT_W'(1);
                        ser_s   = shifted_s[PAT_W-1];
                    end else begin
                        div_s   = div_r + 16'd1;
                        ser_s   = shift_r[PAT_W-1];
                    end
                end
                FIN: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            shift_r <= {PAT_W{1'b0}};
            div_r   <= 16'd0;
            cnt_r   <= {CNT_W{1'b0}};
            ser_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            div_r   <= div_s;
            cnt_r   <= cnt_s;
            ser_r   <= ser_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

`ifdef SEQ_TX_LOOP_EN
    // Copy of the pattern reloaded at every wrap, since the shift register consumes its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r <= {PAT_W{1'b0}};
        end else if (load_s) begin
            pat_r <= pattern;
        end else begin
            pat_r <= pat_r;
        end
    end
`endif

    assign ser_out = ser_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign bit_cnt = cnt_r;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: three instances (DIV=4, 1, 2) against a cycle-count reference model.
module tb_seq_tx;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       start  = 1'b0;
    logic [7:0] pat_in = 8'h00;
    logic [1:0] sel    = 2'd0;
    logic [2:0] start_v, ser_v, busy_v, done_v;
    logic [3:0] cnt0, cnt1, cnt2, cnt_o;
    logic       ser_o, busy_o, done_o;
    logic [6:0] obs;
    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference model: a transmission is "cycles since the start edge"; bit = k/DIV.
    bit         m_active, m_done, m_prev;
    int         m_k;
    int         m_div = 4;
    logic [7:0] m_pat;
    logic [3:0] m_cnt;
    logic       exp_ser, exp_busy;

    always #5 clk = ~clk;

    assign start_v = start ? (3'b001 << sel) : 3'b000;
    assign ser_o   = ser_v[sel];
    assign busy_o  = busy_v[sel];
    assign done_o  = done_v[sel];
    assign obs     = {ser_o, busy_o, done_o, cnt_o};

    always_comb begin
        case (sel)
            2'd0:    cnt_o = cnt0;
            2'd1:    cnt_o = cnt1;
            default: cnt_o = cnt2;
        endcase
    end

    seq_tx #(.PAT_W(8), .DIV(4)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .pattern(pat_in),
        .ser_out(ser_v[0]), .busy(busy_v[0]), .done(done_v[0]), .bit_cnt(cnt0));
    seq_tx #(.PAT_W(8), .DIV(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .pattern(pat_in),
        .ser_out(ser_v[1]), .busy(busy_v[1]), .done(done_v[1]), .bit_cnt(cnt1));
    seq_tx #(.PAT_W(8), .DIV(2)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .pattern(pat_in),
        .ser_out(ser_v[2]), .busy(busy_v[2]), .done(done_v[2]), .bit_cnt(cnt2));

    function automatic logic [6:0] exp_vec();
        return {exp_ser, exp_busy, m_done, m_cnt};
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_done = 1'b0; m_prev = 1'b0; m_k = 0;
        m_pat = 8'h00; m_cnt = 4'd0; exp_ser = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic [7:0] p);
        bit e;
        e = s && !m_prev;
        m_prev = s;
        m_done = 1'b0;
`ifdef SEQ_TX_LOOP_EN
        if (e && m_active) begin
            m_active = 1'b0;
        end else if (e) begin
            m_active = 1'b1; m_k = 0; m_pat = p;
        end else if (m_active) begin
            m_k++;
            if (m_k == 8 * m_div) begin m_k = 0; m_done = 1'b1; end
        end
`else
        if (e) begin
            m_active = 1'b1; m_k = 0; m_pat = p;
        end else if (m_active) begin
            m_k++;
            if (m_k == 8 * m_div) begin m_active = 1'b0; m_done = 1'b1; end
        end
`endif
        if (m_active) begin
            exp_ser = m_pat[7 - m_k / m_div]; exp_busy = 1'b1; m_cnt = 4'(m_k / m_div);
        end else begin
            exp_ser = 1'b0; exp_busy = 1'b0;
            if (m_done) m_cnt = 4'd8;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(start, pat_in);
        @(negedge clk);
    endtask

    task automatic do_reset(input int s, input int d);
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; sel = 2'(s); m_div = d;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ser_v, busy_v, done_v, cnt0, cnt1, cnt2} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_async got=%h want=000000", {ser_v, busy_v, done_v, cnt0, cnt1, cnt2});
        end
        model_reset(); sel = 2'd0; m_div = 4;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] bits;
        int busy_n, done_n, done_k;
        bits = 8'h00; busy_n = 0; done_n = 0; done_k = 0;
        do_reset(0, 4);
        pat_in = 8'b1011_0010; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            start = 1'b0; pat_in = 8'($urandom);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL basic_model cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
            if (k <= 32 && (k - 1) % 4 == 0) bits[7 - (k - 1) / 4] = ser_o;
            busy_n += int'(busy_o);
            if (done_o) begin done_n++; done_k = k; end
        end
        n_checks++;
        if (bits !== 8'hB2) begin n_fail++; $display("FAIL basic_bits got=%h want=b2", bits); end
        n_checks++;
        if (busy_n != 32) begin n_fail++; $display("FAIL basic_busy_len got=%0d want=32", busy_n); end
        n_checks++;
        if (done_n != 1 || done_k != 33) begin
            n_fail++; $display("FAIL basic_done got=%0d@%0d want=1@33", done_n, done_k);
        end
        n_checks++;
        if (cnt_o !== 4'd8) begin n_fail++; $display("FAIL basic_cnt got=%0d want=8", cnt_o); end
    endtask

    task automatic test_held();
        int busy_n, done_n;
        busy_n = 0; done_n = 0;
        do_reset(0, 4);
        pat_in = 8'($urandom); start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cycle();
            if (k == 50) start = 1'b0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL held_model cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
            busy_n += int'(busy_o);
            if (done_o) done_n++;
        end
        n_checks++;
        if (done_n != 1 || busy_n != 32) begin
            n_fail++; $display("FAIL held_once got=%0d dones %0d busy want=1 dones 32 busy", done_n, busy_n);
        end
    endtask

    task automatic test_restart();
        int ones, done_n;
        ones = 0; done_n = 0;
        do_reset(0, 4);
        pat_in = 8'($urandom); start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL restart_pre cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
            if (done_o) done_n++;
        end
        start = 1'b1; pat_in = 8'hFF;
        for (int j = 1; j <= 40; j++) begin
            cycle();
            start = 1'b0; pat_in = 8'($urandom);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL restart_post cyc=%0d got=%b want=%b", j, obs, exp_vec());
            end
            if (j == 1 && cnt_o !== 4'd0) begin
                n_fail++; $display("FAIL restart_cnt0 got=%0d want=0", cnt_o);
            end
            ones += int'(ser_o);
            if (done_o) done_n++;
        end
        n_checks++;
        if (ones != 32 || done_n != 1) begin
            n_fail++; $display("FAIL restart_summary got=%0d ones %0d dones want=32 ones 1 done", ones, done_n);
        end
    endtask

    task automatic test_back_to_back();
        int done_n;
        bit seen;
        done_n = 0; seen = 1'b0;
        do_reset(0, 4);
        pat_in = 8'($urandom); start = 1'b1;
        for (int k = 1; k <= 50 && !seen; k++) begin
            cycle();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_first cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
            seen = done_o;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL b2b_done_timeout got=0 want=1"); end
        start = 1'b1; pat_in = 8'($urandom);
        for (int j = 1; j <= 40; j++) begin
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_second cyc=%0d got=%b want=%b", j, obs, exp_vec());
            end
            if (done_o) done_n++;
        end
        start = 1'b0;
        n_checks++;
        if (done_n != 1) begin n_fail++; $display("FAIL b2b_dones got=%0d want=1", done_n); end
    endtask

    task automatic test_div1();
        logic [7:0] bits;
        int done_k;
        bits = 8'h00; done_k = 0;
        do_reset(1, 1);
        pat_in = 8'hA5; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL div1_model cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
            if (k <= 8) bits[8 - k] = ser_o;
            if (done_o) done_k = k;
        end
        n_checks++;
        if (bits !== 8'hA5 || done_k != 9) begin
            n_fail++; $display("FAIL div1_seq got=%h done@%0d want=a5 done@9", bits, done_k);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(0, 4);
        pat_in = 8'($urandom); start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL rmid_send cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'd0) begin n_fail++; $display("FAIL rmid_async got=%b want=0000000", obs); end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL rmid_idle cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
        end
        rst_n = 1'b0; start = 1'b1; model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL rmid_held cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        int s;
        for (int r = 0; r < 4; r++) begin
            s = int'($urandom_range(0, 2));
            do_reset(s, (s == 0) ? 4 : (s == 1) ? 1 : 2);
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 29) == 0) start = ~start;
                pat_in = 8'($urandom);
                cycle();
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL random r=%0d cyc=%0d got=%b want=%b", r, c, obs, exp_vec());
                end
            end
            start = 1'b0;
        end
    endtask

`ifdef SEQ_TX_LOOP_EN
    task automatic test_loop();
        int dk[3];
        int nd;
        nd = 0;
        do_reset(2, 2);
        pat_in = 8'h81; start = 1'b1;
        for (int k = 1; k <= 80 && nd < 3; k++) begin
            cycle();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL loop_model cyc=%0d got=%b want=%b", k, obs, exp_vec());
            end
            if (done_o) begin dk[nd] = k; nd++; end
        end
        n_checks++;
        if (nd != 3) begin
            n_fail++; $display("FAIL loop_dones got=%0d want=3", nd);
        end else if (dk[1] - dk[0] != 16 || dk[2] - dk[1] != 16) begin
            n_fail++; $display("FAIL loop_spacing got=%0d,%0d want=16,16", dk[1] - dk[0], dk[2] - dk[1]);
        end
        start = 1'b1;
        cycle();
        n_checks++;
        if (busy_o !== 1'b0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL loop_stop got=%b want=%b", obs, exp_vec());
        end
        start = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef SEQ_TX_LOOP_EN
        test_loop();
        test_reset_mid();
        test_random();
`else
        test_basic();
        test_held();
        test_restart();
        test_back_to_back();
        test_div1();
        test_reset_mid();
        test_random();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
